// File: rtl/prog_loader.sv
// prog_loader: streams a text then data segment into CPU memory, then runs the CPU for a fixed window
// Ports: clk/reset (sync, active-high); start pulse; s_valid/s_ready/s_data/s_last word stream;
//   mem_we/mem_addr/mem_wdata write port; cpu_reset, run_done, overflow_err status;
//   text_count/data_count accepted-word counts. Defining PROG_LOADER_CHECKSUM_EN adds chk_sum.
module prog_loader #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] TEXT_BASE = 16'h0000,
  parameter logic [ADDR_W-1:0] DATA_BASE = 16'h0800,
  parameter int DATA_WORDS = 1024,
  parameter int RUN_CYCLES = 5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              run_done,
  output logic              overflow_err,
  output logic [ADDR_W-1:0] text_count,
  output logic [ADDR_W-1:0] data_count
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       chk_sum
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD_TEXT, LOAD_DATA, RUN, DONE} state_t;
  localparam logic [ADDR_W:0] TEXT_LIM = {1'b0, DATA_BASE - TEXT_BASE};
  localparam logic [ADDR_W:0] DATA_LIM = (ADDR_W+1)'(DATA_WORDS);
  state_t state;
  logic [31:0] run_cnt;
  logic in_text, room, wr, restart;
  logic [ADDR_W-1:0] cnt, base;
  always_comb begin
    in_text = state == LOAD_TEXT;
    cnt = in_text ? text_count : data_count;
    base = in_text ? TEXT_BASE : DATA_BASE;
    room = {1'b0, cnt} < (in_text ? TEXT_LIM : DATA_LIM);
    wr = s_valid && s_ready && room;
    restart = start && (state == IDLE || state == DONE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s_ready <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      run_done <= 1'b0;
      overflow_err <= 1'b0;
      text_count <= '0;
      data_count <= '0;
      run_cnt <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: if (restart) begin
          state <= LOAD_TEXT;
          s_ready <= 1'b1;
          cpu_reset <= 1'b1;
          run_done <= 1'b0;
          overflow_err <= 1'b0;
          text_count <= '0;
          data_count <= '0;
        end
        LOAD_TEXT, LOAD_DATA: if (s_valid && s_ready) begin
          if (room) begin
            mem_we <= 1'b1;
            mem_addr <= base + cnt;
            mem_wdata <= s_data;
            if (in_text) text_count <= text_count + ADDR_W'(1);
            else data_count <= data_count + ADDR_W'(1);
          end else overflow_err <= 1'b1;
          if (s_last) begin
            state <= in_text ? LOAD_DATA : RUN;
            s_ready <= in_text;
          end
        end
        // First RUN cycle only releases cpu_reset, so the final write lands before the CPU starts
        RUN: if (cpu_reset) begin
          cpu_reset <= 1'b0;
          run_cnt <= '0;
        end else if (run_cnt == 32'(RUN_CYCLES - 1)) begin
          run_done <= 1'b1;
          state <= DONE;
        end else run_cnt <= run_cnt + 32'd1;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk)
    chk_sum <= (reset || restart) ? '0 : wr ? chk_sum + s_data : chk_sum;
`endif
endmodule
